ahb2apb_bridge: RTL and testbench



---
 rtl/ahb2apb_bridge.sv | 239 +++++++++++++++++++++++
 tb/tb_ahb2apb_bridge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ahb2apb_bridge
// Function : AHB slave that turns each selected AHB transfer into one APB3
//            transfer to one of NO_OF_APB_SLAVES peripherals. It holds the
//            AHB bus with wait states until the APB side finishes. PSLVERR,
//            decode errors and APB timeouts become the two-cycle AHB ERROR.
// Revision : 1.0 - initial release
// ============================================================================
module ahb2apb_bridge #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int NO_OF_APB_SLAVES = 4,
    parameter int SLV_ADDR_LSB     = 12,
    parameter int TIMEOUT_CYCLES   = 16
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    // AHB slave side
    input  logic                        HSEL,
    input  logic [ADDR_WIDTH-1:0]       HADDR,
    input  logic [1:0]                  HTRANS,
    input  logic                        HWRITE,
    input  logic [2:0]                  HSIZE,
    input  logic [DATA_WIDTH-1:0]       HWDATA,
    input  logic                        HREADY,
    output logic                        HREADYOUT,
    output logic [1:0]                  HRESP,
    output logic [DATA_WIDTH-1:0]       HRDATA,
    // APB master side
    output logic [ADDR_WIDTH-1:0]       PADDR,
    output logic [NO_OF_APB_SLAVES-1:0] PSEL,
    output logic                        PENABLE,
    output logic                        PWRITE,
    output logic [DATA_WIDTH-1:0]       PWDATA,
    input  logic [DATA_WIDTH-1:0]       PRDATA,
    input  logic                        PREADY,
    input  logic                        PSLVERR
);

    // The slave-index field is one bit wider than needed to address all
    // slaves, so an address just above the last slave window (e.g. 0x4000
    // with four slaves) decodes to an out-of-range index and is rejected
    // instead of aliasing back onto slave 0.
    localparam int c_IDX_W = $clog2(NO_OF_APB_SLAVES) + 1;
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [c_IDX_W-1:0] c_NSLV       = c_IDX_W'(NO_OF_APB_SLAVES);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT    = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [2:0]         c_MAX_SIZE   = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0]         c_RESP_OKAY  = 2'b00;
    localparam logic [1:0]         c_RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR_1  = 3'd4,
        ST_ERR_2  = 3'd5
    } state_t;

    state_t                        state_q,     state_d;
    logic [ADDR_WIDTH-1:0]         addr_q,      addr_d;
    logic                          write_q,     write_d;
    logic [c_CNT_W-1:0]            cnt_q,       cnt_d;
    logic                          hreadyout_q, hreadyout_d;
    logic [1:0]                    hresp_q,     hresp_d;
    logic [DATA_WIDTH-1:0]         hrdata_q,    hrdata_d;
    logic [ADDR_WIDTH-1:0]         paddr_q,     paddr_d;
    logic [NO_OF_APB_SLAVES-1:0]   psel_q,      psel_d;
    logic                          penable_q,   penable_d;
    logic                          pwrite_q,    pwrite_d;
    logic [DATA_WIDTH-1:0]         pwdata_q,    pwdata_d;

    logic                          w_accept;
    logic                          w_bad;
    logic [c_IDX_W-1:0]            w_hidx;
    logic [c_CNT_W-1:0]            w_cnt_inc;
    logic                          w_unused_htrans0;

    // Only NONSEQ/SEQ start a transfer; IDLE and BUSY get the default
    // zero-wait OKAY, so the low HTRANS bit carries no information here.
    assign w_accept         = HSEL & HREADY & HTRANS[1];
    assign w_hidx           = HADDR[SLV_ADDR_LSB +: c_IDX_W];
    assign w_bad            = (w_hidx >= c_NSLV) | (HSIZE > c_MAX_SIZE);
    assign w_cnt_inc        = cnt_q + c_CNT_W'(1);
    assign w_unused_htrans0 = HTRANS[0];

    // Next-state logic; every output register is then loaded with the value
    // that belongs to the state being entered, so outputs are glitch-free.
    always_comb begin
        logic [c_IDX_W-1:0]          sel_idx;
        logic [NO_OF_APB_SLAVES-1:0] sel_dec;

        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        cnt_d       = cnt_q;
        hrdata_d    = hrdata_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        hreadyout_d = 1'b1;
        hresp_d     = c_RESP_OKAY;
        psel_d      = '0;
        penable_d   = 1'b0;
        sel_idx     = '0;
        sel_dec     = '0;

        case (state_q)
            ST_IDLE, ST_ERR_2: begin
                // The second ERROR cycle is also a legal address phase.
                state_d = ST_IDLE;
                if (w_accept) begin
                    addr_d  = HADDR;
                    write_d = HWRITE;
                    if (w_bad) begin
                        state_d = ST_ERR_1;
                    end else if (HWRITE) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_WDATA: begin
                // HWDATA is valid only in the AHB data phase, one cycle
                // after the address was accepted.
                pwdata_d = HWDATA;
                state_d  = ST_SETUP;
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        state_d = ST_ERR_1;
                    end else begin
                        if (!write_q) begin
                            hrdata_d = PRDATA;
                        end
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = w_cnt_inc;
                    if ((TIMEOUT_CYCLES != 0) && (w_cnt_inc == c_TIMEOUT)) begin
                        state_d = ST_ERR_1;
                    end
                end
            end
            ST_ERR_1: begin
                state_d = ST_ERR_2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // One-hot select from the address of the transfer being entered;
        // an out-of-range index yields no select at all.
        sel_idx = addr_d[SLV_ADDR_LSB +: c_IDX_W];
        for (int i = 0; i < NO_OF_APB_SLAVES; i++) begin
            if (sel_idx == c_IDX_W'(i)) begin
                sel_dec[i] = 1'b1;
            end
        end

        case (state_d)
            ST_WDATA: begin
                hreadyout_d = 1'b0;
            end
            ST_SETUP: begin
                hreadyout_d = 1'b0;
                paddr_d     = addr_d;
                pwrite_d    = write_d;
                psel_d      = sel_dec;
            end
            ST_ACCESS: begin
                hreadyout_d = 1'b0;
                psel_d      = sel_dec;
                penable_d   = 1'b1;
            end
            ST_ERR_1: begin
                hreadyout_d = 1'b0;
                hresp_d     = c_RESP_ERROR;
            end
            ST_ERR_2: begin
                hresp_d     = c_RESP_ERROR;
            end
            default: begin
            end
        endcase
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            cnt_q       <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= c_RESP_OKAY;
            hrdata_q    <= '0;
            paddr_q     <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            cnt_q       <= cnt_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb2apb_bridge
// Function : Self-checking bench for ahb2apb_bridge: a table of directed
//            transfers with hand-computed results, plus directed sequences
//            for reset, pipelining and timeout corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb2apb_bridge;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        hsel, hsel2;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    logic        HREADYOUT, PENABLE, PWRITE;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA, PADDR, PWDATA;
    logic [3:0]  PSEL;

    logic        hreadyout2, penable2, pwrite2;
    logic [1:0]  hresp2;
    logic [31:0] hrdata2, paddr2, pwdata2;
    logic [3:0]  psel2;

    int n_total = 0;
    int n_bad   = 0;

    always #5 HCLK = ~HCLK;

    ahb2apb_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADYOUT), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .HRDATA(HRDATA), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    ahb2apb_bridge #(.TIMEOUT_CYCLES(0)) dut_nto (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel2), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(hreadyout2), .HREADYOUT(hreadyout2), .HRESP(hresp2),
        .HRDATA(hrdata2), .PADDR(paddr2), .PSEL(psel2), .PENABLE(penable2),
        .PWRITE(pwrite2), .PWDATA(pwdata2), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic [31:0] haddr;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [31:0] hwdata;
        logic [31:0] prdata;
        int          nwait;      // ACCESS cycles with PREADY=0 before PREADY=1
        logic        slverr;
        logic [3:0]  exp_psel;
        int          exp_waits;  // cycles with HREADYOUT=0
        logic [1:0]  exp_hresp;
        logic [31:0] exp_hrdata;
    } xfer_t;

    xfer_t tbl[9];

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Run one AHB transfer through the bridge, playing the APB slave.
    task automatic do_xfer(input xfer_t r, input string tag);
        int   waits;
        int   acc;
        int   stab;
        logic [3:0] psel_seen;
        logic done;
        waits = 0; acc = 0; stab = 0; psel_seen = '0; done = 1'b0;
        hsel = 1'b1; HTRANS = 2'b10; HADDR = r.haddr; HWRITE = r.hwrite;
        HSIZE = r.hsize; PRDATA = r.prdata; PREADY = 1'b0; PSLVERR = 1'b0;
        step();
        hsel = 1'b0; HTRANS = 2'b00; HWDATA = r.hwdata;
        for (int c = 0; c < 40 && !done; c++) begin
            if (HREADYOUT) begin
                done = 1'b1;
            end else begin
                waits++;
                psel_seen |= PSEL;
                if (PSEL != 4'b0) begin
                    if (PADDR !== r.haddr || PWRITE !== r.hwrite ||
                        (r.hwrite && PWDATA !== r.hwdata) || !$onehot(PSEL))
                        stab++;
                end
                if (PENABLE) begin
                    PREADY  = (acc >= r.nwait);
                    PSLVERR = r.slverr && (acc >= r.nwait);
                    acc++;
                end else begin
                    PREADY  = 1'b0;
                    PSLVERR = 1'b0;
                end
                step();
            end
        end
        PREADY = 1'b0; PSLVERR = 1'b0;
        check({tag, " completed within budget"}, 64'(done), 64'd1);
        check({tag, " wait states"}, 64'(waits), 64'(r.exp_waits));
        check({tag, " psel"}, 64'(psel_seen), 64'(r.exp_psel));
        check({tag, " hresp"}, 64'(HRESP), 64'(r.exp_hresp));
        check({tag, " hrdata"}, 64'(HRDATA), 64'(r.exp_hrdata));
        check({tag, " apb hold/onehot errors"}, 64'(stab), 64'd0);
        step();
        check({tag, " hresp after idle"}, 64'(HRESP), 64'd0);
        check({tag, " hreadyout after idle"}, 64'(HREADYOUT), 64'd1);
    endtask

    initial begin
        int   cnt;
        xfer_t fresh;

        //            haddr         wr    sz    hwdata        prdata        nw sl   psel     w  resp   hrdata
        tbl[0] = '{32'h0000_1004, 1'b0, 3'd2, 32'h0,         32'hDEAD_BEEF, 0, 1'b0, 4'b0010, 2, 2'b00, 32'hDEAD_BEEF};
        tbl[1] = '{32'h0000_3010, 1'b1, 3'd2, 32'h1234_5678, 32'hAAAA_5555, 2, 1'b0, 4'b1000, 5, 2'b00, 32'hDEAD_BEEF};
        tbl[2] = '{32'h0000_2008, 1'b0, 3'd2, 32'h0,         32'hCAFE_F00D, 1, 1'b0, 4'b0100, 3, 2'b00, 32'hCAFE_F00D};
        tbl[3] = '{32'h0000_0000, 1'b0, 3'd2, 32'h0,         32'h1111_2222, 0, 1'b1, 4'b0001, 3, 2'b01, 32'hCAFE_F00D};
        tbl[4] = '{32'h0000_1000, 1'b1, 3'd2, 32'h5A5A_5A5A, 32'h3333_4444, 1, 1'b1, 4'b0010, 5, 2'b01, 32'hCAFE_F00D};
        tbl[5] = '{32'h0000_4000, 1'b0, 3'd2, 32'h0,         32'h5555_6666, 0, 1'b0, 4'b0000, 1, 2'b01, 32'hCAFE_F00D};
        tbl[6] = '{32'h0000_1000, 1'b0, 3'd3, 32'h0,         32'h7777_8888, 0, 1'b0, 4'b0000, 1, 2'b01, 32'hCAFE_F00D};
        tbl[7] = '{32'h0000_2FFC, 1'b1, 3'd1, 32'h0000_BEEF, 32'h9999_AAAA, 0, 1'b0, 4'b0100, 3, 2'b00, 32'hCAFE_F00D};
        tbl[8] = '{32'h0000_7000, 1'b0, 3'd0, 32'h0,         32'hBBBB_CCCC, 0, 1'b0, 4'b0000, 1, 2'b01, 32'hCAFE_F00D};

        HRESET = 1'b1; hsel = 1'b0; hsel2 = 1'b0; HADDR = '0; HTRANS = 2'b00;
        HWRITE = 1'b0; HSIZE = 3'd2; HWDATA = '0; PRDATA = '0; PREADY = 1'b0;
        PSLVERR = 1'b0;
        repeat (3) step();

        // Reset state
        check("reset hreadyout", 64'(HREADYOUT), 64'd1);
        check("reset hresp", 64'(HRESP), 64'd0);
        check("reset hrdata", 64'(HRDATA), 64'd0);
        check("reset paddr", 64'(PADDR), 64'd0);
        check("reset psel", 64'(PSEL), 64'd0);
        check("reset penable", 64'(PENABLE), 64'd0);
        check("reset pwrite", 64'(PWRITE), 64'd0);
        check("reset pwdata", 64'(PWDATA), 64'd0);
        check("reset nto hreadyout", 64'(hreadyout2), 64'd1);
        HRESET = 1'b0;
        step();

        // Table-driven transfers
        for (int i = 0; i < 9; i++) begin
            do_xfer(tbl[i], $sformatf("row%0d", i));
        end

        // IDLE and BUSY while selected: zero-wait OKAY, no APB activity
        hsel = 1'b1; HADDR = 32'h0000_1000; HTRANS = 2'b01;
        step();
        check("busy hreadyout", 64'(HREADYOUT), 64'd1);
        check("busy psel", 64'(PSEL), 64'd0);
        check("busy hresp", 64'(HRESP), 64'd0);
        HTRANS = 2'b00;
        step();
        check("idle hreadyout", 64'(HREADYOUT), 64'd1);
        check("idle psel", 64'(PSEL), 64'd0);
        hsel = 1'b0;

        // Back-to-back: write issued in the read's completion cycle
        hsel = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0000; HWRITE = 1'b0;
        HSIZE = 3'd2; PRDATA = 32'h0A0B_0C0D;
        step();
        HTRANS = 2'b00;
        check("b2b read setup psel", 64'(PSEL), 64'b0001);
        step();
        PREADY = 1'b1;
        step();
        PREADY = 1'b0;
        check("b2b read done hreadyout", 64'(HREADYOUT), 64'd1);
        check("b2b read data", 64'(HRDATA), 64'h0A0B_0C0D);
        HTRANS = 2'b10; HADDR = 32'h0000_2000; HWRITE = 1'b1;
        step();
        HTRANS = 2'b00; hsel = 1'b0; HWDATA = 32'hFEED_FACE;
        check("b2b wdata hreadyout", 64'(HREADYOUT), 64'd0);
        check("b2b wdata psel", 64'(PSEL), 64'd0);
        step();
        check("b2b write setup psel", 64'(PSEL), 64'b0100);
        check("b2b write setup penable", 64'(PENABLE), 64'd0);
        check("b2b write setup paddr", 64'(PADDR), 64'h0000_2000);
        check("b2b write setup pwdata", 64'(PWDATA), 64'hFEED_FACE);
        check("b2b write setup pwrite", 64'(PWRITE), 64'd1);
        PREADY = 1'b1;
        step();
        check("b2b write access penable", 64'(PENABLE), 64'd1);
        step();
        PREADY = 1'b0;
        check("b2b write done hreadyout", 64'(HREADYOUT), 64'd1);
        check("b2b write done hresp", 64'(HRESP), 64'd0);
        check("b2b write keeps hrdata", 64'(HRDATA), 64'h0A0B_0C0D);

        // Timeout after 16 ACCESS cycles
        hsel = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_1000; HWRITE = 1'b0;
        step();
        hsel = 1'b0; HTRANS = 2'b00;
        step();
        cnt = 0;
        for (int c = 0; c < 100 && PENABLE; c++) begin
            cnt++;
            step();
        end
        check("timeout access cycles", 64'(cnt), 64'd16);
        check("timeout err1 psel", 64'(PSEL), 64'd0);
        check("timeout err1 hresp", 64'(HRESP), 64'd1);
        check("timeout err1 hreadyout", 64'(HREADYOUT), 64'd0);
        step();
        check("timeout err2 hresp", 64'(HRESP), 64'd1);
        check("timeout err2 hreadyout", 64'(HREADYOUT), 64'd1);
        step();
        check("timeout recovered hresp", 64'(HRESP), 64'd0);

        // Timeout disabled: waits indefinitely
        hsel2 = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_1000; HWRITE = 1'b0;
        step();
        hsel2 = 1'b0; HTRANS = 2'b00;
        repeat (40) step();
        check("nto still waiting hreadyout", 64'(hreadyout2), 64'd0);
        check("nto still in access", 64'(penable2), 64'd1);
        check("nto psel", 64'(psel2), 64'b0010);
        check("nto hresp", 64'(hresp2), 64'd0);
        PREADY = 1'b1; PRDATA = 32'h600D_CAFE;
        step();
        PREADY = 1'b0;
        check("nto done hreadyout", 64'(hreadyout2), 64'd1);
        check("nto done hrdata", 64'(hrdata2), 64'h600D_CAFE);
        check("idle bridge untouched", 64'(PSEL), 64'd0);

        // Reset mid-ACCESS drops APB signals at once
        hsel = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_1008; HWRITE = 1'b0;
        step();
        hsel = 1'b0; HTRANS = 2'b00;
        step();
        check("pre-reset in access", 64'(PENABLE), 64'd1);
        HRESET = 1'b1;
        #1;
        check("async reset psel", 64'(PSEL), 64'd0);
        check("async reset penable", 64'(PENABLE), 64'd0);
        check("async reset hreadyout", 64'(HREADYOUT), 64'd1);
        step();
        HRESET = 1'b0;
        step();
        fresh = '{32'h0000_1004, 1'b0, 3'd2, 32'h0, 32'h0BAD_F00D, 0, 1'b0,
                  4'b0010, 2, 2'b00, 32'h0BAD_F00D};
        do_xfer(fresh, "post-reset read");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
